pairwise_gate_pipe: RTL and testbench

//  Parametrised, pipelined successor to the two-output pairwise AND block.

---
 rtl/pairwise_gate_pipe.sv | 89 ++++++++
 tb/tb_pairwise_gate_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pairwise_gate_pipe.sv
// Pairwise operand gate with a stallable ready/valid delay pipeline.
// Channel k combines operands k and k+1. A saturating counter tracks all-ones results as they leave the block.
module pairwise_gate_pipe #(
    parameter int N_CH   = 2,
    parameter int WIDTH  = 1,
    parameter int STAGES = 1,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(N_CH+1)*WIDTH-1:0] a,
    input  logic [1:0]                op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*WIDTH-1:0]     q,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          match_cnt
);

    localparam int QW = N_CH * WIDTH;

    logic [QW-1:0]    op_result;
    logic [QW-1:0]    data_reg [STAGES];
    logic [STAGES-1:0] valid_reg;
    logic             stall;
    logic             transfer;
    logic [CNT_W-1:0] match_cnt_reg;
    logic [CNT_W-1:0] match_cnt_next;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] lo_opnd;
            logic [WIDTH-1:0] hi_opnd;
            assign lo_opnd = a[gi*WIDTH +: WIDTH];
            assign hi_opnd = a[(gi+1)*WIDTH +: WIDTH];
            assign op_result[gi*WIDTH +: WIDTH] =
                (op == 2'b00) ? (lo_opnd & hi_opnd) :
                (op == 2'b01) ? (lo_opnd | hi_opnd) :
                (op == 2'b10) ? (lo_opnd ^ hi_opnd) :
                                ~(lo_opnd & hi_opnd);
        end
    endgenerate

    // One global stall freezes every stage, bubbles included, so beats keep their spacing.
    assign out_valid = valid_reg[STAGES-1];
    assign q         = data_reg[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign transfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_reg[s] <= '0;
            end
        end else if (!stall) begin
            valid_reg[0] <= in_valid;
            data_reg[0]  <= op_result;
            for (int s = 1; s < STAGES; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                data_reg[s]  <= data_reg[s-1];
            end
        end
    end

    // Clear outranks counting; the counter sticks at its maximum instead of wrapping.
    always_comb begin
        match_cnt_next = match_cnt_reg;
        if (cnt_clr) begin
            match_cnt_next = '0;
        end else if (transfer && (&q) && (match_cnt_reg != {CNT_W{1'b1}})) begin
            match_cnt_next = match_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt_reg <= '0;
        end else begin
            match_cnt_reg <= match_cnt_next;
        end
    end

    assign match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_pairwise_gate_pipe.sv
// Directed bench for pairwise_gate_pipe: default, 3-stage and 4x8-bit 2-stage instances.
// The wide instance runs a random handshake stream against a queue-based reference model.
module tb_pairwise_gate_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance: N_CH=2, WIDTH=1, STAGES=1
    logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_cnt_clr;
    logic [2:0] d1_a;
    logic [1:0] d1_op, d1_q;
    logic [7:0] d1_cnt;

    // STAGES=3 instance
    logic       d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_cnt_clr;
    logic [2:0] d3_a;
    logic [1:0] d3_op, d3_q;
    logic [7:0] d3_cnt;

    // N_CH=4, WIDTH=8, STAGES=2 instance
    logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_cnt_clr;
    logic [39:0] d4_a;
    logic [1:0]  d4_op;
    logic [31:0] d4_q;
    logic [7:0]  d4_cnt;

    pairwise_gate_pipe dut1 (
        .clk(clk), .reset(reset), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .op(d1_op), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .q(d1_q), .cnt_clr(d1_cnt_clr), .match_cnt(d1_cnt)
    );

    pairwise_gate_pipe #(.N_CH(2), .WIDTH(1), .STAGES(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .a(d3_a), .op(d3_op), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .q(d3_q), .cnt_clr(d3_cnt_clr), .match_cnt(d3_cnt)
    );

    pairwise_gate_pipe #(.N_CH(4), .WIDTH(8), .STAGES(2), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .op(d4_op), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .q(d4_q), .cnt_clr(d4_cnt_clr), .match_cnt(d4_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_q(input logic [39:0] av, input logic [1:0] o);
        logic [31:0] r;
        logic [7:0]  x, y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = av[i*8 +: 8];
            y = av[(i+1)*8 +: 8];
            case (o)
                2'd0:    r[i*8 +: 8] = x & y;
                2'd1:    r[i*8 +: 8] = x | y;
                2'd2:    r[i*8 +: 8] = x ^ y;
                default: r[i*8 +: 8] = ~(x & y);
            endcase
        end
        return r;
    endfunction

    logic [31:0] sb[$];
    logic [31:0] exp_word;
    logic [63:0] rnd;
    logic        acc, xfer;
    int          model_cnt;

    initial begin
        reset = 1'b1;
        d1_in_valid = 0; d1_out_ready = 0; d1_cnt_clr = 0; d1_a = '0; d1_op = '0;
        d3_in_valid = 0; d3_out_ready = 0; d3_cnt_clr = 0; d3_a = '0; d3_op = '0;
        d4_in_valid = 0; d4_out_ready = 0; d4_cnt_clr = 0; d4_a = '0; d4_op = '0;
        model_cnt = 0;

        // Reset state
        tick(); tick();
        chk("rst_d1_out_valid", d1_out_valid, 0);
        chk("rst_d1_q", d1_q, 0);
        chk("rst_d1_cnt", d1_cnt, 0);
        chk("rst_d3_out_valid", d3_out_valid, 0);
        chk("rst_d4_q", d4_q, 0);
        reset = 1'b0;
        #1;
        chk("rst_d1_in_ready", d1_in_ready, 1);
        chk("rst_d3_in_ready", d3_in_ready, 1);

        // Single all-ones beat, then op cycling on a=110
        d1_a = 3'b111; d1_op = 2'b00; d1_in_valid = 1; d1_out_ready = 1;
        tick();
        chk("t1_out_valid", d1_out_valid, 1);
        chk("t1_q", d1_q, 2'b11);
        chk("t1_cnt_before", d1_cnt, 0);
        d1_a = 3'b110; d1_op = 2'b00;
        tick();
        chk("t2_and_q", d1_q, 2'b10);
        chk("t1_cnt", d1_cnt, 1);
        d1_op = 2'b01;
        tick();
        chk("t2_or_q", d1_q, 2'b11);
        d1_op = 2'b10;
        tick();
        chk("t2_xor_q", d1_q, 2'b01);
        chk("t2_cnt", d1_cnt, 2);
        d1_op = 2'b11;
        tick();
        chk("t2_nand_q", d1_q, 2'b01);
        chk("t2_nand_valid", d1_out_valid, 1);
        d1_in_valid = 0;
        tick();
        chk("t2_drained", d1_out_valid, 0);
        chk("t2_cnt_final", d1_cnt, 2);

        // Single-stage stall: q held, in_ready low
        d1_a = 3'b101; d1_op = 2'b01; d1_in_valid = 1; d1_out_ready = 0;
        tick();
        chk("stall_q", d1_q, 2'b11);
        d1_a = 3'b000; d1_op = 2'b00;
        #1;
        chk("stall_in_ready", d1_in_ready, 0);
        tick();
        chk("stall_q_held", d1_q, 2'b11);
        chk("stall_valid_held", d1_out_valid, 1);
        chk("stall_cnt_held", d1_cnt, 2);
        d1_in_valid = 0; d1_out_ready = 1;
        #1;
        chk("release_in_ready", d1_in_ready, 1);
        tick();
        chk("release_valid", d1_out_valid, 0);
        chk("release_cnt", d1_cnt, 3);

        // Saturation and clear-wins
        d1_a = 3'b111; d1_op = 2'b00; d1_in_valid = 1; d1_out_ready = 1;
        repeat (300) tick();
        chk("sat_cnt", d1_cnt, 255);
        tick();
        chk("sat_no_wrap", d1_cnt, 255);
        d1_cnt_clr = 1;
        tick();
        chk("clr_wins", d1_cnt, 0);
        d1_cnt_clr = 0;
        tick();
        chk("after_clr_cnt", d1_cnt, 1);
        d1_in_valid = 0;
        tick();
        chk("after_clr_cnt2", d1_cnt, 2);
        chk("after_clr_valid", d1_out_valid, 0);

        // Three-stage pipeline with backpressure
        d3_a = 3'b111; d3_op = 2'b00; d3_in_valid = 1; d3_out_ready = 0;
        tick();
        chk("s3_lat1", d3_out_valid, 0);
        d3_a = 3'b110; d3_op = 2'b10;
        tick();
        chk("s3_lat2", d3_out_valid, 0);
        d3_in_valid = 0;
        tick();
        chk("s3_first_valid", d3_out_valid, 1);
        chk("s3_first_q", d3_q, 2'b11);
        chk("s3_in_ready_low", d3_in_ready, 0);
        tick();
        chk("s3_hold_q1", d3_q, 2'b11);
        chk("s3_hold_valid", d3_out_valid, 1);
        tick();
        chk("s3_hold_q2", d3_q, 2'b11);
        d3_out_ready = 1;
        #1;
        chk("s3_in_ready_high", d3_in_ready, 1);
        tick();
        chk("s3_second_valid", d3_out_valid, 1);
        chk("s3_second_q", d3_q, 2'b01);
        tick();
        chk("s3_empty", d3_out_valid, 0);
        chk("s3_cnt", d3_cnt, 1);

        // Reset with three beats in flight
        d3_a = 3'b111; d3_op = 2'b00; d3_in_valid = 1;
        tick(); tick(); tick();
        chk("rf_full_valid", d3_out_valid, 1);
        chk("rf_cnt_before", d3_cnt, 1);
        reset = 1'b1;
        tick();
        chk("rf_valid", d3_out_valid, 0);
        chk("rf_cnt", d3_cnt, 0);
        chk("rf_q", d3_q, 0);
        reset = 1'b0; d3_in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rf_no_stale", d3_out_valid, 0);
        end

        // Random handshakes on the wide instance against a scoreboard
        for (int cyc = 0; cyc < 400; cyc++) begin
            rnd = {$urandom(), $urandom()};
            d4_in_valid  = ($urandom_range(0, 2) != 0);
            d4_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                d4_a  = '1;
                d4_op = 2'b00;
            end else begin
                d4_a  = rnd[39:0];
                d4_op = 2'($urandom_range(0, 3));
            end
            #1;
            acc  = d4_in_valid & d4_in_ready;
            xfer = d4_out_valid & d4_out_ready;
            if (xfer) begin
                chk("t6_unexpected_beat", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    chk("t6_q", d4_q, exp_word);
                    if (exp_word == 32'hFFFF_FFFF && model_cnt < 255) model_cnt++;
                end
            end
            if (acc) sb.push_back(model_q(d4_a, d4_op));
            tick();
        end
        d4_in_valid = 0; d4_out_ready = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (d4_out_valid && sb.size() > 0) begin
                exp_word = sb.pop_front();
                chk("t6_drain_q", d4_q, exp_word);
                if (exp_word == 32'hFFFF_FFFF && model_cnt < 255) model_cnt++;
            end else if (d4_out_valid) begin
                chk("t6_extra_beat", 1, 0);
            end
            tick();
        end
        chk("t6_all_delivered", sb.size(), 0);
        chk("t6_cnt", d4_cnt, model_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
